// File: rtl/fft_agu_if.sv
// fft_agu port bundle: start/inverse in, sweep status and addresses out.
// `inverse` exists only when FFT_AGU_INVERSE_EN is defined.
interface fft_agu_if #(
  parameter int LOG2N = 8
);
  logic             start;
`ifdef FFT_AGU_INVERSE_EN
  logic             inverse;
`endif
  logic             busy;
  logic             done;
  logic [7:0]       tw_addr;
  logic             bf_valid;
  logic [LOG2N-1:0] bf_addr_a;
  logic [LOG2N-1:0] bf_addr_b;
  logic [2:0]       bf_stage;
  logic             bf_last;

  modport master (
    input  start,
`ifdef FFT_AGU_INVERSE_EN
    input  inverse,
`endif
    output busy,
    output done,
    output tw_addr,
    output bf_valid,
    output bf_addr_a,
    output bf_addr_b,
    output bf_stage,
    output bf_last
  );

  modport slave (
    output start,
`ifdef FFT_AGU_INVERSE_EN
    output inverse,
`endif
    input  busy,
    input  done,
    input  tw_addr,
    input  bf_valid,
    input  bf_addr_a,
    input  bf_addr_b,
    input  bf_stage,
    input  bf_last
  );
endinterface

// File: rtl/fft_agu.sv
// Radix-2 DIT FFT address generator: twiddle ROM address plus aligned RAM legs.
// Define FFT_AGU_INVERSE_EN to add the `inverse` (conjugate twiddle) input.
module fft_agu #(
  parameter int LOG2N     = 8,
  parameter int STAGE_GAP = 2
) (
  input logic      clk,
  input logic      rst_n,
  fft_agu_if.master bus
);

  localparam int W = LOG2N;
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] BMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [3:0]   SEND  = 4'(LOG2N);
  localparam logic [3:0]   SLAST = 4'(LOG2N - 1);
  localparam logic [3:0]   GMAX  = 4'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    FIN
  } state_t;

  state_t         state;
  logic [3:0]     st;
  logic [3:0]     gcnt;
  logic [W-1:0]   bc;
  logic           busy_q;
  logic           done_q;

  logic           iss_v;
  logic           iss_last;
  logic [W-1:0]   iss_a;
  logic [W-1:0]   iss_b;
  logic [2:0]     iss_s;
  logic [7:0]     tw_q;

  logic           bf_v;
  logic           bf_l;
  logic [W-1:0]   bf_a;
  logic [W-1:0]   bf_b;
  logic [2:0]     bf_s;

`ifdef FFT_AGU_INVERSE_EN
  logic           inv_q;
  logic           inv_sel;
`endif

  logic           nxt_iss;
  logic [3:0]     ns;
  logic [W-1:0]   nb;
  logic [2:0]     s3;
  logic [3:0]     sh1;
  logic [W-1:0]   half;
  logic [W-1:0]   jj;
  logic [W-1:0]   grp;
  logic [W-1:0]   na;
  logic [W-1:0]   nb2;
  logic [7:0]     tw_f;
  logic [7:0]     tw_n;
  logic           nlast;

  // Look ahead to the butterfly issued in the next cycle so tw_addr is a flop.
  always_comb begin
    nxt_iss = 1'b0;
    ns      = st;
    nb      = bc;
    unique case (state)
      IDLE: begin
        nxt_iss = bus.start;
        ns      = '0;
        nb      = '0;
      end
      RUN: begin
        nxt_iss = (bc != BMAX);
        nb      = bc + ONE;
      end
      GAP: begin
        nxt_iss = (gcnt == GMAX) && (st != SEND);
        nb      = '0;
      end
      FIN: begin
        nxt_iss = 1'b0;
      end
    endcase
  end

  always_comb begin
    s3    = ns[2:0];
    sh1   = {1'b0, s3} + 4'd1;
    half  = ONE << s3;
    jj    = nb & (half - ONE);
    grp   = nb >> s3;
    na    = (grp << sh1) | jj;
    nb2   = na + half;
    tw_f  = 8'(jj) << (3'd7 - s3);
    nlast = (ns == SLAST) && (nb == BMAX);
  end

`ifdef FFT_AGU_INVERSE_EN
  always_comb begin
    inv_sel = (state == IDLE) ? bus.inverse : inv_q;
    tw_n    = inv_sel ? (8'd0 - tw_f) : tw_f;
  end
`else
  assign tw_n = tw_f;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      st       <= '0;
      gcnt     <= '0;
      bc       <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      iss_v    <= 1'b0;
      iss_last <= 1'b0;
      iss_a    <= '0;
      iss_b    <= '0;
      iss_s    <= '0;
      tw_q     <= '0;
      bf_v     <= 1'b0;
      bf_l     <= 1'b0;
      bf_a     <= '0;
      bf_b     <= '0;
      bf_s     <= '0;
`ifdef FFT_AGU_INVERSE_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      bf_v  <= iss_v;
      bf_l  <= iss_v & iss_last;
      bf_a  <= iss_a;
      bf_b  <= iss_b;
      bf_s  <= iss_s;
      iss_v <= nxt_iss;
      if (nxt_iss) begin
        tw_q     <= tw_n;
        iss_a    <= na;
        iss_b    <= nb2;
        iss_s    <= s3;
        iss_last <= nlast;
      end
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RUN;
            st     <= '0;
            bc     <= '0;
            busy_q <= 1'b1;
`ifdef FFT_AGU_INVERSE_EN
            inv_q  <= bus.inverse;
`endif
          end
        end
        RUN: begin
          if (bc == BMAX) begin
            state <= GAP;
            bc    <= '0;
            st    <= st + 4'd1;
            gcnt  <= '0;
          end else begin
            bc <= bc + ONE;
          end
        end
        GAP: begin
          if (gcnt == GMAX) begin
            if (st == SEND) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            gcnt <= gcnt + 4'd1;
          end
        end
        FIN: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tw_addr   = tw_q;
  assign bus.bf_valid  = bf_v;
  assign bus.bf_addr_a = bf_a;
  assign bus.bf_addr_b = bf_b;
  assign bus.bf_stage  = bf_s;
  assign bus.bf_last   = bf_l;

endmodule

// File: tb/tb_fft_agu.sv
// Bench for fft_agu: N=256 and N=4 instances against a cycle-indexed schedule model.
// Inverse-twiddle checks are active when FFT_AGU_INVERSE_EN is defined.
module tb_fft_agu;

`ifdef FFT_AGU_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_agu_if #(.LOG2N(8)) bus8 ();
  fft_agu_if #(.LOG2N(2)) bus2 ();

  fft_agu #(.LOG2N(8), .STAGE_GAP(2)) u8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  fft_agu #(.LOG2N(2), .STAGE_GAP(1)) u2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  int vectors = 0;
  int miscompares = 0;
  int k[2] = '{-1, -1};
  int mtw[2] = '{0, 0};
  bit minv[2] = '{1'b0, 1'b0};
  int vcnt[2] = '{0, 0};
  int cyc = 0;
  int dcyc = -1;
  bit pbusy = 1'b0;
  bit hold8 = 1'b0;
  bit inv_drv = 1'b0;

  task automatic chk(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  // Butterfly issued at transform cycle kk, if any.
  function automatic bit iss(int L, int G, int kk, output int s, output int b);
    int p;
    p = (1 << (L - 1)) + G;
    s = 0;
    b = 0;
    if (kk < 0) return 1'b0;
    s = kk / p;
    b = kk % p;
    return (s < L) && (b < (1 << (L - 1)));
  endfunction

  function automatic int twf(int s, int b, bit inv);
    int half, j, n;
    half = 1 << s;
    j = b % half;
    n = (j * (128 / half)) % 256;
    return inv ? (256 - n) % 256 : n;
  endfunction

  task automatic upd(int i, bit stv, bit inv);
    int L, G, p, s, b;
    L = (i == 1) ? 2 : 8;
    G = (i == 1) ? 1 : 2;
    p = (1 << (L - 1)) + G;
    if (k[i] < 0) begin
      if (stv) begin
        k[i] = 0;
        minv[i] = inv & INV_EN;
      end
    end else begin
      k[i]++;
      if (k[i] > L * p) k[i] = -1;
    end
    if (iss(L, G, k[i], s, b)) mtw[i] = twf(s, b, minv[i]);
  endtask

  task automatic model_reset();
    k[0] = -1;
    k[1] = -1;
    mtw[0] = 0;
    mtw[1] = 0;
  endtask

  task automatic cmp(int i, bit busy, bit done, int tw, bit v,
                     int a, int bb, int stg, bit last);
    int L, G, p, lp, hb, kk, s, b, half, ea;
    bit ev;
    string t;
    L  = (i == 1) ? 2 : 8;
    G  = (i == 1) ? 1 : 2;
    t  = (i == 1) ? "n4" : "n256";
    p  = (1 << (L - 1)) + G;
    lp = L * p;
    hb = 1 << (L - 1);
    kk = k[i];
    chk({t, ".busy"}, int'(busy), int'(kk >= 0));
    chk({t, ".done"}, int'(done), int'(kk == lp));
    chk({t, ".tw_addr"}, tw, mtw[i]);
    ev = (kk >= 1) && iss(L, G, kk - 1, s, b);
    chk({t, ".bf_valid"}, int'(v), int'(ev));
    if (ev) begin
      half = 1 << s;
      ea = (b / half) * 2 * half + (b % half);
      chk({t, ".bf_addr_a"}, a, ea);
      chk({t, ".bf_addr_b"}, bb, ea + half);
      chk({t, ".bf_stage"}, stg, s);
      chk({t, ".bf_last"}, int'(last), int'((s == L - 1) && (b == hb - 1)));
    end else begin
      chk({t, ".bf_last_idle"}, int'(last), 0);
    end
    if (kk == 0) vcnt[i] = 0;
    if (v) vcnt[i]++;
    if (kk == lp) chk({t, ".valid_count"}, vcnt[i], L * hb);
    if (i == 0 && !minv[0]) begin
      if (kk == 5)    chk("lit.s0b5.tw", tw, 0);
      if (kk == 6)    chk("lit.s0b5.a", a, 10);
      if (kk == 6)    chk("lit.s0b5.b", bb, 11);
      if (kk == 403)  chk("lit.s3b13.tw", tw, 80);
      if (kk == 404)  chk("lit.s3b13.a", a, 21);
      if (kk == 404)  chk("lit.s3b13.b", bb, 29);
      if (kk == 1010) chk("lit.s7b100.tw", tw, 100);
      if (kk == 1011) chk("lit.s7b100.a", a, 100);
      if (kk == 1011) chk("lit.s7b100.b", bb, 228);
      if (kk == 1038) chk("lit.last.flag", int'(last), 1);
      if (kk == 1038) chk("lit.last.a", a, 127);
      if (kk == 1038) chk("lit.last.b", bb, 255);
      if (kk == 1040) chk("lit.done1040", int'(done), 1);
    end
`ifdef FFT_AGU_INVERSE_EN
    if (i == 0 && minv[0]) begin
      if (kk == 911) chk("lit.inv.s7b1", tw, 255);
      if (kk == 131) chk("lit.inv.s1b1", tw, 192);
      if (kk == 130) chk("lit.inv.s1b0", tw, 0);
    end
`endif
    if (i == 1) begin
      if (kk == 2) chk("lit.n4.k2.a", a, 2);
      if (kk == 2) chk("lit.n4.k2.b", bb, 3);
      if (kk == 3) chk("lit.n4.gap", int'(v), 0);
      if (kk == 4) chk("lit.n4.tw64", tw, 64);
      if (kk == 5) chk("lit.n4.k5.a", a, 1);
      if (kk == 5) chk("lit.n4.k5.b", bb, 3);
      if (kk == 6) chk("lit.n4.done6", int'(done), 1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      cmp(0, bus8.busy, bus8.done, int'(bus8.tw_addr), bus8.bf_valid,
          int'(bus8.bf_addr_a), int'(bus8.bf_addr_b),
          int'(bus8.bf_stage), bus8.bf_last);
      cmp(1, bus2.busy, bus2.done, int'(bus2.tw_addr), bus2.bf_valid,
          int'(bus2.bf_addr_a), int'(bus2.bf_addr_b),
          int'(bus2.bf_stage), bus2.bf_last);
      if (bus8.done) dcyc = cyc;
      if (bus8.busy && !pbusy && hold8 && dcyc >= 0)
        chk("n256.b2b_gap", cyc - dcyc, 2);
      pbusy = bus8.busy;
    end
  end

  task automatic drive(bit s8, bit s2, bit iv);
    bus8.start = s8;
    bus2.start = s2;
    inv_drv = iv;
`ifdef FFT_AGU_INVERSE_EN
    bus8.inverse = iv;
    bus2.inverse = 1'b0;
`endif
  endtask

  task automatic step(bit s8, bit s2, bit iv);
    @(posedge clk);
    if (rst_n) begin
      upd(0, bus8.start, inv_drv);
      upd(1, bus2.start, 1'b0);
    end else begin
      model_reset();
    end
    #2;
    drive(s8, s2, iv);
  endtask

  function automatic bit rb(int m);
    return ($urandom % m) == 0;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 1'b0);

    // Start, let it run to cycle 300 with stray starts, then abort.
    drive(1'b1, 1'b1, 1'b0);
    repeat (301) step(rb(8), rb(4), 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort.busy", int'(bus8.busy), 0);
    chk("abort.done", int'(bus8.done), 0);
    chk("abort.tw", int'(bus8.tw_addr), 0);
    chk("abort.valid", int'(bus8.bf_valid), 0);
    chk("abort.a", int'(bus8.bf_addr_a), 0);
    chk("abort.b", int'(bus8.bf_addr_b), 0);
    chk("abort.stage", int'(bus8.bf_stage), 0);
    chk("abort.last", int'(bus8.bf_last), 0);
    chk("abort.n4.busy", int'(bus2.busy), 0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // start held high: back-to-back transforms.
    hold8 = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    repeat (2200) step(1'b1, 1'b1, 1'b0);
    hold8 = 1'b0;
    repeat (1100) step(1'b0, rb(4), 1'b0);

    // Random starts and random inverse selection.
    repeat (3000) step(rb(64), rb(4), rb(2));
    repeat (1100) step(1'b0, rb(4), 1'b0);

    // One clean inverse transform.
    drive(1'b1, 1'b0, 1'b1);
    repeat (1045) step(1'b0, rb(4), 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
